// File: rtl/pipeline_debug_scanner_if.sv
// pipeline_debug_scanner_if
// Snapshot stream from the debug scanner to its consumer: one (kind, addr,
// data) beat per ready/valid handshake.
//   out_valid  beat valid (scanner -> consumer)
//   out_ready  consumer ready (consumer -> scanner)
//   out_kind   0 = register beat, 1 = memory beat
//   out_addr   register index (zero-extended) or memory byte address
//   out_data   captured register / memory value
//   out_last   final beat of the dump
interface pipeline_debug_scanner_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output out_valid, out_kind, out_addr, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_kind, out_addr, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/pipeline_debug_scanner.sv
// pipeline_debug_scanner
// Debug controller sitting between the board top and pipeline_cpu. It holds
// the CPU in reset for RESET_CYCLES after system reset, counts retired
// instructions from the write-back stage, and on a start pulse (or when the
// count reaches commit_limit) freezes the CPU and streams a snapshot of
// registers 0..NUM_REGS-1 followed by MEM_WORDS memory words.
//   clk, reset          system clock, synchronous active-high reset
//   start               dump request in RUN, resume in DONE
//   commit_limit        auto-dump count (0 disables)
//   cpu_resetn          CPU reset (active low)
//   cpu_clk_en          CPU clock enable, 0 freezes the CPU
//   cpu_valid, wb_pc    CPU stage valids (bit 0 = WB) and WB pc
//   rf_addr / rf_data   register probe
//   mem_addr / mem_data memory probe (byte address)
//   dbg                 snapshot stream (master side)
//   commit_count        retired instructions since reset (saturating)
//   busy, done          dumping / dump finished
module pipeline_debug_scanner #(
  parameter int unsigned RESET_CYCLES = 10,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned MEM_WORDS    = 16,
  parameter logic [31:0] MEM_BASE     = 32'h0000_0000,
  parameter int unsigned RD_LAT       = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [31:0]                     commit_limit,
  output logic                            cpu_resetn,
  output logic                            cpu_clk_en,
  input  logic [4:0]                      cpu_valid,
  input  logic [31:0]                     wb_pc,
  output logic [4:0]                      rf_addr,
  input  logic [31:0]                     rf_data,
  output logic [31:0]                     mem_addr,
  input  logic [31:0]                     mem_data,
  pipeline_debug_scanner_if.master        dbg,
  output logic [31:0]                     commit_count,
  output logic                            busy,
  output logic                            done
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [MW-1:0] MEM_LAST = MW'(MEM_WORDS - 1);
  localparam logic [4:0]    REG_LAST = 5'(NUM_REGS - 1);
  localparam logic [1:0]    LAT      = 2'(RD_LAT);

  localparam logic [2:0] S_RESET_HOLD = 3'd0;
  localparam logic [2:0] S_RUN        = 3'd1;
  localparam logic [2:0] S_DUMP_REG   = 3'd2;
  localparam logic [2:0] S_DUMP_MEM   = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  logic [2:0]    state;
  logic [RW-1:0] rst_cnt;
  logic [1:0]    lat_cnt;
  logic [MW-1:0] mem_idx;
  logic [31:0]   last_pc;
  logic          prev_wb_vld;
  logic          wb_new;
  logic          count_inc;
  logic          limit_hit;
  logic          in_mem;

  // Only the WB valid bit matters for retirement counting.
  logic unused_cpu_valid;
  assign unused_cpu_valid = ^cpu_valid[4:1];

  // A WB instruction is new unless the same pc was already valid last cycle;
  // a branch-to-self running back-to-back therefore counts once.
  assign wb_new    = cpu_valid[0] && ((wb_pc != last_pc) || !prev_wb_vld);
  assign count_inc = (state == S_RUN) && wb_new && (commit_count != 32'hFFFF_FFFF);
  // Compared only on an increment, so resuming at equality never retriggers.
  assign limit_hit = count_inc && (commit_limit != 32'd0) &&
                     ((commit_count + 32'd1) == commit_limit);
  assign in_mem    = (state == S_DUMP_MEM);

  assign cpu_resetn = (state != S_RESET_HOLD);
  assign cpu_clk_en = (state == S_RESET_HOLD) || (state == S_RUN);
  assign busy       = (state == S_DUMP_REG) || (state == S_DUMP_MEM);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RESET_HOLD;
      rst_cnt       <= '0;
      lat_cnt       <= '0;
      mem_idx       <= '0;
      rf_addr       <= '0;
      mem_addr      <= MEM_BASE;
      commit_count  <= '0;
      last_pc       <= '0;
      prev_wb_vld   <= 1'b0;
      dbg.out_valid <= 1'b0;
      dbg.out_kind  <= 1'b0;
      dbg.out_addr  <= '0;
      dbg.out_data  <= '0;
      dbg.out_last  <= 1'b0;
    end else begin
      prev_wb_vld <= cpu_valid[0];
      if (count_inc) commit_count <= commit_count + 32'd1;
      if ((state == S_RUN) && wb_new) last_pc <= wb_pc;

      case (state)
        S_RESET_HOLD: begin
          if (rst_cnt == RST_LAST) state <= S_RUN;
          else rst_cnt <= rst_cnt + 1'b1;
        end
        S_RUN: begin
          if (start || limit_hit) begin
            state    <= S_DUMP_REG;
            rf_addr  <= '0;
            mem_addr <= MEM_BASE;
            mem_idx  <= '0;
            lat_cnt  <= '0;
          end
        end
        S_DUMP_REG, S_DUMP_MEM: begin
          if (!dbg.out_valid) begin
            // Address has been stable for RD_LAT cycles: capture this cycle.
            if (lat_cnt == LAT) begin
              dbg.out_valid <= 1'b1;
              dbg.out_kind  <= in_mem;
              dbg.out_addr  <= in_mem ? mem_addr : {27'd0, rf_addr};
              dbg.out_data  <= in_mem ? mem_data : rf_data;
              dbg.out_last  <= in_mem && (mem_idx == MEM_LAST);
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end else if (dbg.out_ready) begin
            dbg.out_valid <= 1'b0;
            dbg.out_last  <= 1'b0;
            lat_cnt       <= '0;
            if (!in_mem) begin
              if (rf_addr == REG_LAST) state <= S_DUMP_MEM;
              else rf_addr <= rf_addr + 5'd1;
            end else if (mem_idx == MEM_LAST) begin
              state <= S_DONE;
            end else begin
              mem_idx  <= mem_idx + 1'b1;
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        S_DONE: begin
          if (start) state <= S_RUN;
        end
        default: state <= S_RESET_HOLD;
      endcase
    end
  end

endmodule

// File: doc/pipeline_debug_scanner.md
# pipeline_debug_scanner

Synthesizable debug controller between the board/top level and `pipeline_cpu`.
- Sequences CPU reset release.
- Counts retired instructions from the write-back stage.
- On a start pulse or a commit-count limit, freezes the CPU and dumps a parametrised range of registers and memory words as a ready/valid stream of (kind, address, data) beats.
- Replaces hand-driven `rf_addr`/`mem_addr` probing with a repeatable, bounded snapshot usable both on hardware and in simulation.

## Interface
Parameters
- `RESET_CYCLES`, 10: cycles `cpu_resetn` is held low after reset (≥1).
- `NUM_REGS`, 32: registers dumped, indices 0..NUM_REGS-1 (1..32).
- `MEM_WORDS`, 16: memory words dumped (≥1).
- `MEM_BASE`, 32'h0000_0000: first memory byte address, word aligned.
- `RD_LAT`, 0: cycles from address change to valid `rf_data`/`mem_data` (0..3).

Ports
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse: dump request (RUN), or resume (DONE).
- `commit_limit`  in  32  auto-dump when `commit_count` reaches this value; 0 disables.
- `cpu_resetn`  out  1  drives CPU `resetn`.
- `cpu_clk_en`  out  1  CPU clock enable; 0 freezes the CPU.
- `cpu_valid`  in  5  CPU stage valid bits; bit 0 is WB.
- `wb_pc`  in  32  CPU `WB_pc`.
- `rf_addr`  out  5  register probe address.
- `rf_data`  in  32  register probe data.
- `mem_addr`  out  32  memory probe byte address.
- `mem_data`  in  32  memory probe data.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  consumer ready.
- `out_kind`  out  1  0 = register, 1 = memory.
- `out_addr`  out  32  register index (zero-extended) or memory byte address.
- `out_data`  out  32  captured value.
- `out_last`  out  1  final beat of the dump.
- `commit_count`  out  32  retired instructions since reset.
- `busy`  out  1  in DUMP_REG or DUMP_MEM.
- `done`  out  1  in DONE.

## Operation
- States: RESET_HOLD → RUN → DUMP_REG → DUMP_MEM → DONE → (start) RUN.

RESET_HOLD
- `cpu_resetn`=0, `cpu_clk_en`=1.
- Counter runs RESET_CYCLES cycles, then the FSM enters RUN.
- `start` is ignored.

RUN
- `cpu_resetn`=1, `cpu_clk_en`=1.
- `commit_count` increments on a cycle with `cpu_valid[0]`=1 AND (`wb_pc` ≠ last counted pc OR previous cycle `cpu_valid[0]`=0).
- Counter saturates at 32'hFFFF_FFFF.
- Limitation: a branch-to-self executing back-to-back counts once.
- Trigger: `start`=1, OR `commit_limit`≠0 and `commit_count`==`commit_limit` after an increment this cycle. The next state is DUMP_REG.

DUMP phases
- `cpu_clk_en`=0 throughout; `cpu_resetn` stays 1; `commit_count` frozen.
- Per beat: address presented, wait RD_LAT cycles, capture data into `out_data`, assert `out_valid`. Hold all `out_*` stable until `out_ready`=1, then advance.
- DUMP_REG walks `rf_addr` 0..NUM_REGS-1.
- DUMP_MEM walks `mem_addr` = MEM_BASE + 4·i, i = 0..MEM_WORDS-1. Wraps modulo 2^32.
- `out_last`=1 only on memory beat MEM_WORDS-1. Its handshake enters DONE.
- `start` is ignored while busy.

DONE
- `done`=1, `cpu_clk_en`=0.
- `start` returns the FSM to RUN; the count continues.
- Auto-trigger re-arms only after the count changes, so there is no immediate retrigger at equality.

Reset values and reset mid-operation
- `reset`=1 in any state, including mid-beat: next state RESET_HOLD.
- Outputs: `cpu_resetn`=0, `cpu_clk_en`=1, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `commit_count`=0, `rf_addr`=0, `mem_addr`=MEM_BASE, `out_*` data fields 0.
- An in-flight beat is discarded.

## Timing
- After `reset` deasserts, `cpu_resetn` rises after exactly RESET_CYCLES cycles.
- `start` sampled high at edge T: `cpu_clk_en`=0 and `rf_addr`=0 from T+1.
- Beat: address visible at cycle A; data sampled at end of cycle A+RD_LAT; `out_valid`=1 from cycle A+RD_LAT+1.
- Handshake at cycle H: next address visible at H+1; `out_valid`=0 at H+1.
- With `out_ready` tied 1: one beat per RD_LAT+2 cycles. Full dump = (NUM_REGS+MEM_WORDS)·(RD_LAT+2) cycles.
- Auto-trigger: the count reaches the limit at edge T, and the CPU is frozen from T+1. No further instruction retires after the limiting one.

## Test plan
- Reset sequencing: `reset` high 3 cycles, then low → `cpu_resetn` low for exactly 10 cycles, then high; `commit_count`=0, `out_valid`=0.
- Manual dump, defaults, `out_ready`=1, `start` at cycle 200 → 48 beats over 96 cycles.
  - Beats 0..31: kind 0, addr 0..31.
  - Beats 32..47: kind 1, addr 0x00..0x3C.
  - `out_last` only on beat 47; then `done`=1 and `cpu_clk_en`=0.
- Backpressure: `out_ready` low 5 cycles on beat 3 → `out_addr`=3 and `out_data` held stable, no beat lost or duplicated; RD_LAT=2 gives a 4-cycle beat spacing.
- Auto-trigger: `commit_limit`=20, model retires at distinct pcs → freeze on the cycle after count hits 20; count stays 20.
  - A repeated `wb_pc` with `cpu_valid[0]` held is not recounted.
- Resume and retrigger: `start` in DONE → RUN, count continues from 20 without immediate retrigger.
  - `start` while busy is ignored.
- Reset mid-dump at beat 10 → `out_valid`=0, `busy`=0, `commit_count`=0; the full RESET_HOLD sequence repeats.
